fpu_issue_ctrl: RTL and testbench

Multi-cycle sequencer for the floating-point ALU in the datapath. Accepts one COP1 arithmetic instruction at a time from decode and holds the ALU opcode/function stable for the operation's latency. Stalls the integer pipeline while busy, then issues a single-cycle writeback strobe to the FP register file. Decodes format (single/double) and rejects unsupported encodings.

---
 rtl/fpu_issue_if.sv | 32 +++
 rtl/fpu_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_if.sv
// Issue/writeback bundle between decode, the FP issue controller and the FP register file.
interface fpu_issue_if;
    logic        issue_valid;
    logic [4:0]  cop;
    logic [5:0]  func;
    logic [4:0]  fd;
    logic        flush;
    logic        issue_ready;
    logic        stall;
    logic        busy;
    logic [4:0]  alu_cop;
    logic [5:0]  alu_func;
    logic        fp_wr_en;
    logic [4:0]  fp_wr_addr;
    logic        wb_double;
    logic        illegal_op;
    logic [15:0] ops_done;

    // Decode side: presents instructions and flushes, observes status.
    modport master (
        output issue_valid, cop, func, fd, flush,
        input  issue_ready, stall, busy, alu_cop, alu_func, fp_wr_en, fp_wr_addr,
               wb_double, illegal_op, ops_done
    );

    // Controller side.
    modport slave (
        input  issue_valid, cop, func, fd, flush,
        output issue_ready, stall, busy, alu_cop, alu_func, fp_wr_en, fp_wr_addr,
               wb_double, illegal_op, ops_done
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Multi-cycle sequencer for the FP ALU: accepts one COP1 op, holds the ALU controls for the
// op's latency, stalls decode meanwhile, then strobes a single-cycle register-file write.
module fpu_issue_ctrl #(
    parameter int unsigned ADD_LAT   = 2,
    parameter int unsigned MUL_LAT_S = 4,
    parameter int unsigned MUL_LAT_D = 6,
    parameter int unsigned DIV_LAT_S = 12,
    parameter int unsigned DIV_LAT_D = 25
) (
    input  logic        clk,
    input  logic        reset,
    fpu_issue_if.slave  bus
);

    localparam logic [4:0] CopS = 5'b10000;
    localparam logic [4:0] CopD = 5'b10001;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  cop_q, cop_d;
    logic [5:0]  func_q, func_d;
    logic [4:0]  fd_q, fd_d;
    logic        illegal_q, illegal_d;
    logic [15:0] ops_done_q;

    logic       is_double;
    logic [4:0] lat;
    logic       legal;
    logic       accept;

    // Decode EXEC latency of the presented op; zero marks an unsupported function.
    always_comb begin
        lat       = '0;
        is_double = (bus.cop == CopD);
        case (bus.func)
            6'd0, 6'd1: lat = is_double ? 5'(ADD_LAT + 1) : 5'(ADD_LAT);
            6'd2:       lat = is_double ? 5'(MUL_LAT_D) : 5'(MUL_LAT_S);
            6'd3:       lat = is_double ? 5'(DIV_LAT_D) : 5'(DIV_LAT_S);
            6'd5, 6'd6, 6'd7: lat = 5'd1;
            default:    lat = '0;
        endcase
    end

    // Doubles need an even register pair.
    assign legal  = ((bus.cop == CopS) || is_double) && (lat != 5'd0) &&
                    !(is_double && bus.fd[0]);
    assign accept = bus.issue_valid && (state_q == StIdle) && !bus.flush;

    // Next-state logic: latch on accept, count down EXEC, single WB cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cop_d     = cop_q;
        func_d    = func_q;
        fd_d      = fd_q;
        illegal_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (legal) begin
                        cop_d   = bus.cop;
                        func_d  = bus.func;
                        fd_d    = bus.fd;
                        cnt_d   = lat - 5'd1;
                        state_d = StExec;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StExec: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (cnt_q == 5'd0) begin
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and latched-field registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cop_q      <= '0;
            func_q     <= '0;
            fd_q       <= '0;
            illegal_q  <= 1'b0;
            ops_done_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cop_q     <= cop_d;
            func_q    <= func_d;
            fd_q      <= fd_d;
            illegal_q <= illegal_d;
            // A flush can only land in EXEC, so every WB cycle is a committed write.
            if (state_q == StWb) begin
                ops_done_q <= ops_done_q + 16'd1;
            end
        end
    end

    // Outputs: ALU controls only while an op is in flight, writeback fields only on the strobe.
    always_comb begin
        bus.issue_ready = (state_q == StIdle);
        bus.busy        = (state_q != StIdle);
        bus.stall       = bus.issue_valid && (state_q != StIdle);
        bus.alu_cop     = (state_q != StIdle) ? cop_q : 5'd0;
        bus.alu_func    = (state_q != StIdle) ? func_q : 6'd0;
        bus.fp_wr_en    = (state_q == StWb);
        bus.fp_wr_addr  = (state_q == StWb) ? fd_q : 5'd0;
        bus.wb_double   = (state_q == StWb) && (cop_q == CopD);
        bus.illegal_op  = illegal_q;
        bus.ops_done    = ops_done_q;
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: the driver pushes the expected outcome of every issued
// op; an independent monitor pops and compares whenever the controller produces a response.
module tb_fpu_issue_ctrl;

    localparam int ADD_LAT   = 2;
    localparam int MUL_LAT_S = 4;
    localparam int MUL_LAT_D = 6;
    localparam int DIV_LAT_S = 12;
    localparam int DIV_LAT_D = 25;

    localparam logic [4:0] CopS = 5'b10000;
    localparam logic [4:0] CopD = 5'b10001;

    localparam int KWb    = 0;  // op completes with a write
    localparam int KIll   = 1;  // op rejected
    localparam int KFlush = 2;  // op killed by flush after len EXEC cycles
    localparam int KReset = 3;  // op abandoned by reset

    typedef struct {
        int          kind;
        logic [4:0]  cop;
        logic [5:0]  func;
        logic [4:0]  addr;
        bit          dbl;
        int          len;
        int          acc;
        logic [15:0] done_before;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    logic [15:0] exp_done = '0;

    fpu_issue_if bus ();

    fpu_issue_ctrl #(
        .ADD_LAT  (ADD_LAT),
        .MUL_LAT_S(MUL_LAT_S),
        .MUL_LAT_D(MUL_LAT_D),
        .DIV_LAT_S(DIV_LAT_S),
        .DIV_LAT_D(DIV_LAT_D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Label each cycle by the rising edge that starts it.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference latency tables indexed by function code; 0 = unsupported.
    function automatic int ref_latency(input logic [4:0] c, input logic [5:0] f);
        int lat_s[8];
        int lat_d[8];
        lat_s = '{ADD_LAT, ADD_LAT, MUL_LAT_S, DIV_LAT_S, 0, 1, 1, 1};
        lat_d = '{ADD_LAT + 1, ADD_LAT + 1, MUL_LAT_D, DIV_LAT_D, 0, 1, 1, 1};
        if (f > 6'd7) return 0;
        return (c == CopD) ? lat_d[int'(f)] : lat_s[int'(f)];
    endfunction

    function automatic bit ref_legal(input logic [4:0] c, input logic [5:0] f,
                                     input logic [4:0] d);
        if (c != CopS && c != CopD) return 0;
        if (ref_latency(c, f) == 0) return 0;
        if (c == CopD && d[0]) return 0;
        return 1;
    endfunction

    // flush_k: 0 = none, k>0 = assert flush on the k-th cycle after accept, -1 = reset follows.
    task automatic issue(input logic [4:0] c, input logic [5:0] f, input logic [4:0] d,
                         input int flush_k, output int waited);
        exp_t it;
        int   lat;
        bit   ok;
        bus.cop = c;
        bus.func = f;
        bus.fd = d;
        bus.issue_valid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.issue_ready && waited < 64);
        if (!bus.issue_ready) begin
            check("issue_ready_timeout", 32'(bus.issue_ready), 32'd1);
            bus.issue_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        lat = ref_latency(c, f);
        ok = ref_legal(c, f, d);
        it.cop = c;
        it.func = f;
        it.addr = d;
        it.dbl = (c == CopD);
        it.acc = cyc;
        it.len = lat;
        it.done_before = exp_done;
        if (!ok) it.kind = KIll;
        else if (flush_k < 0) it.kind = KReset;
        else if (flush_k >= 1 && flush_k <= lat) begin
            it.kind = KFlush;
            it.len = flush_k;
        end else begin
            it.kind = KWb;
            exp_done = exp_done + 16'd1;
        end
        exp_q.push_back(it);
        if (ok && flush_k > 0) begin
            repeat (flush_k - 1) begin
                @(posedge clk);
                #1;
            end
            bus.flush = 1'b1;
            @(posedge clk);
            #1;
            bus.flush = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("wait_idle", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output exp_t it);
        check("response_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) it = exp_q.pop_front();
        else it = '{kind: -1, cop: '0, func: '0, addr: '0, dbl: 0, len: 0, acc: 0,
                    done_before: '0};
    endtask

    // Monitor: samples on the falling edge, independent of the driver's sequencing.
    initial begin : monitor
        exp_t it;
        int   exec_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (exec_cnt != 0) begin
                    pop_exp(it);
                    check("reset_abandon_kind", 32'(it.kind), 32'(KReset));
                end
                exec_cnt = 0;
            end else begin
                if (!bus.fp_wr_en) begin
                    check("wr_addr_quiet", 32'(bus.fp_wr_addr), 32'd0);
                    check("wb_double_quiet", 32'(bus.wb_double), 32'd0);
                end
                if (!bus.busy) check("alu_quiet", 32'({bus.alu_cop, bus.alu_func}), 32'd0);
                if (bus.illegal_op) begin
                    pop_exp(it);
                    check("illegal_kind", 32'(it.kind), 32'(KIll));
                    check("illegal_timing", 32'(cyc), 32'(it.acc));
                end
                if (bus.busy && !bus.fp_wr_en) begin
                    exec_cnt++;
                    check("exec_has_op", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        check("exec_alu_cop", 32'(bus.alu_cop), 32'(exp_q[0].cop));
                        check("exec_alu_func", 32'(bus.alu_func), 32'(exp_q[0].func));
                    end
                end else if (bus.fp_wr_en) begin
                    pop_exp(it);
                    check("wb_kind", 32'(it.kind), 32'(KWb));
                    check("wb_addr", 32'(bus.fp_wr_addr), 32'(it.addr));
                    check("wb_double", 32'(bus.wb_double), 32'(it.dbl));
                    check("wb_exec_len", 32'(exec_cnt), 32'(it.len));
                    check("wb_timing", 32'(cyc), 32'(it.acc + it.len));
                    check("wb_ops_done", 32'(bus.ops_done), 32'(it.done_before));
                    check("wb_alu_held", 32'({bus.alu_cop, bus.alu_func}),
                          32'({it.cop, it.func}));
                    exec_cnt = 0;
                end else if (exec_cnt != 0) begin
                    pop_exp(it);
                    check("flush_kind", 32'(it.kind), 32'(KFlush));
                    check("flush_exec_len", 32'(exec_cnt), 32'(it.len));
                    exec_cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checked", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : driver
        int w;
        logic [4:0] c, d;
        logic [5:0] f;
        int fk;
        logic [5:0] funcs[7];
        funcs = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd6, 6'd7};
        bus.issue_valid = 1'b0;
        bus.cop = '0;
        bus.func = '0;
        bus.fd = '0;
        bus.flush = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_wr_en", 32'(bus.fp_wr_en), 32'd0);
        check("rst_illegal", 32'(bus.illegal_op), 32'd0);
        check("rst_ops_done", 32'(bus.ops_done), 32'd0);
        reset = 1'b0;

        // add.s to f4 with a second op held behind it.
        issue(CopS, 6'd0, 5'd4, 0, w);
        bus.cop = CopS;
        bus.func = 6'd6;
        bus.fd = 5'd8;
        bus.issue_valid = 1'b1;
        check("stall_exec1", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        check("stall_exec2", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        check("stall_wb", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        check("stall_idle", 32'(bus.stall), 32'd0);
        check("ops_done_after_add", 32'(bus.ops_done), 32'd1);
        issue(CopS, 6'd6, 5'd8, 0, w);
        wait_idle();

        // div.d, illegal encodings, flush in EXEC and in WB.
        issue(CopD, 6'd3, 5'd6, 0, w);
        issue(5'b10100, 6'd0, 5'd2, 0, w);
        issue(CopS, 6'd8, 5'd2, 0, w);
        issue(CopD, 6'd2, 5'd5, 0, w);
        issue(CopS, 6'd2, 5'd10, 3, w);
        issue(CopS, 6'd7, 5'd12, 2, w);
        wait_idle();
        check("ops_done_mid", 32'(bus.ops_done), 32'(exp_done));

        // Flush in IDLE blocks the accept.
        bus.cop = CopS;
        bus.func = 6'd0;
        bus.fd = 5'd2;
        bus.issue_valid = 1'b1;
        bus.flush = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_flush_blocks", 32'(bus.busy), 32'd0);
        end
        bus.issue_valid = 1'b0;
        bus.flush = 1'b0;

        // Reset during EXEC of div.s, then an immediate accept.
        issue(CopS, 6'd3, 5'd14, -1, w);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_mid_wr_en", 32'(bus.fp_wr_en), 32'd0);
        check("rst_mid_alu", 32'({bus.alu_cop, bus.alu_func}), 32'd0);
        check("rst_mid_ops_done", 32'(bus.ops_done), 32'd0);
        reset = 1'b0;
        exp_done = '0;
        issue(CopD, 6'd0, 5'd2, 0, w);
        check("accept_after_reset", 32'(w), 32'd1);
        wait_idle();

        // Jump the completion counter close to its wrap point, then let mov.s ops wrap it.
        force dut.ops_done_q = 16'hFFFD;
        #1;
        release dut.ops_done_q;
        exp_done = 16'hFFFD;
        for (int i = 0; i < 4; i++) issue(CopS, 6'd6, 5'(2 * i), 0, w);
        wait_idle();
        check("ops_done_wrap", 32'(bus.ops_done), 32'd1);

        // Random mix with random gaps, flushes and held issues.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0: c = 5'($urandom);
                1, 2, 3, 4: c = CopS;
                default: c = CopD;
            endcase
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 6)];
            d = 5'($urandom);
            fk = 0;
            if ($urandom_range(0, 4) == 0) fk = $urandom_range(1, ref_latency(c, f) + 1);
            issue(c, f, d, fk, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("ops_done_final", 32'(bus.ops_done), 32'(exp_done));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
